alu_regfile: RTL and testbench
==============================

Name: alu_regfile

Overview:
- Execution core of the 8-bit CPU: a 4-entry register file (two combinational read ports, one synchronous write port) feeding an 8-bit combinational ALU.
- Has a write-back mux selecting ALU result or memory load data.
- Sits under the datapath; PC logic and memory stay outside this block.

Parameters:
- WIDTH, 8, data word width in bits (all arithmetic below assumes 8).
- NREGS, 4, number of architectural registers (address width 2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rd  in  2  destination / read-port-1 address (ra=0, rb=1, rc=2, re=3).
- rs  in  2  source / read-port-2 address (same encoding).
- imm  in  8  immediate operand.
- alu_op  in  4  ALU operation select (encoding below).
- alu_src  in  1  1: ALU B = imm; 0: ALU B = reg[rs].
- mem_to_reg  in  1  1: write-back data = mem_data; 0: write-back data = alu_out.
- mem_data  in  8  load data from memory.
- reg_wr  in  1  register write enable.
- alu_out  out  8  ALU result (combinational).
- alu_zero  out  1  1 when alu_out == 0x00.
- mem_wr_data  out  8  store data = reg[rd] (read port 1).

Behaviour:
- Operands:
  - A = reg[rd].
  - B = alu_src ? imm : reg[rs].
- Read ports:
  - Combinational, no bypass.
  - A write in cycle N is visible on reads only after the rising edge that commits it.
  - Same-cycle read of the register being written returns the old value.
- Write:
  - On rising edge, if !rst && reg_wr: reg[rd] <= (mem_to_reg ? mem_data : alu_out).
  - Exactly one register written per cycle; rd == rs is legal.
- Reset:
  - Synchronous; on rising edge with rst=1 all four registers go to 0x00.
  - reg_wr is ignored while rst=1.
  - Outputs are combinational. After reset with alu_op=CPY, alu_out=0x00, alu_zero=1, mem_wr_data=0x00.
  - Reset mid-sequence discards any pending write in that cycle.
- ALU opcodes (4-bit), results truncated to 8 bits:
  - 0 CPY: B.
  - 1 ADD: A+B, carry discarded, wraps mod 256.
  - 2 SUB: A-B, wraps mod 256.
  - 3 AND: A&B.
  - 4 OR: A|B.
  - 5 XOR: A^B.
  - 6 NAND: ~(A&B).
  - 7 NOT: ~A.
  - 8 SHL: A << B[2:0], zero fill.
  - 9 SHR: A >> B[2:0], logical, zero fill.
  - 10–15 reserved: result 0x00.
- alu_zero is derived from the final alu_out for every opcode, including reserved ones.
- No X propagation: all outputs are defined for every input combination once registers are reset.
- Latency:
  - ALU: 0 cycles.
  - Register write: 1 cycle (visible after next edge).

Test Plan:
- Reset: rst=1 for one edge, then reads of ra..re via rd/rs give 0x00; CPY with alu_src=0 gives alu_out=0x00, alu_zero=1.
- Load path: reg_wr=1, mem_to_reg=1, writing mem_data=0x7A/0x8A/0x9A/0xFD to ra/rb/rc/re on successive edges -> each readback on mem_wr_data returns that value; same-cycle read shows the old value.
- ALU via imm: ra=0x7A, alu_src=1:
  - imm=0x86, ADD -> alu_out=0x00, alu_zero=1 (wrap).
  - imm=0x0F, AND -> 0x0A.
  - SHL imm=1 -> 0xF4.
- Register ops: rb=0x8A, rc=0x9A, rd=rb, rs=rc:
  - SUB -> 0xF0.
  - XOR -> 0x10.
  - NOT -> 0x75.
  - With reg_wr=1, mem_to_reg=0, rb=0x10 after the edge.
- Write gating: reg_wr=0 with mem_data=0x55 -> no register changes. Reset asserted with reg_wr=1 -> all registers 0x00, write dropped.
- Reserved opcode 12 -> alu_out=0x00, alu_zero=1.

Source files
------------

// File: rtl/alu_regfile.sv
// Execution core of the 8-bit CPU: four-entry register file with two
// combinational read ports and one synchronous write port, feeding the ALU.
module alu_regfile #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       rd,
   input  logic [1:0]       rs,
   input  logic [WIDTH-1:0] imm,
   input  logic [3:0]       alu_op,
   input  logic             alu_src,
   input  logic             mem_to_reg,
   input  logic [WIDTH-1:0] mem_data,
   input  logic             reg_wr,
   output logic [WIDTH-1:0] alu_out,
   output logic             alu_zero,
   output logic [WIDTH-1:0] mem_wr_data
);

   typedef enum logic [3:0] {
      OP_CPY  = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_XOR  = 4'd5,
      OP_NAND = 4'd6,
      OP_NOT  = 4'd7,
      OP_SHL  = 4'd8,
      OP_SHR  = 4'd9
   } alu_op_e;

   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] wb_data;
   logic [2:0]       shamt;

   // Reads are straight from the array: a write only shows after its edge.
   assign op_a        = regs[rd];
   assign op_b        = alu_src ? imm : regs[rs];
   assign mem_wr_data = regs[rd];
   assign shamt       = op_b[2:0];

   always_comb begin
      alu_out = '0;
      case (alu_op)
         OP_CPY:  alu_out = op_b;
         OP_ADD:  alu_out = op_a + op_b;
         OP_SUB:  alu_out = op_a - op_b;
         OP_AND:  alu_out = op_a & op_b;
         OP_OR:   alu_out = op_a | op_b;
         OP_XOR:  alu_out = op_a ^ op_b;
         OP_NAND: alu_out = ~(op_a & op_b);
         OP_NOT:  alu_out = ~op_a;
         OP_SHL:  alu_out = op_a << shamt;
         OP_SHR:  alu_out = op_a >> shamt;
         default: alu_out = '0;
      endcase
   end

   assign alu_zero = (alu_out == '0);
   assign wb_data  = mem_to_reg ? mem_data : alu_out;

   // Reset takes priority, so a write requested in a reset cycle is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (reg_wr) begin
         regs[rd] <= wb_data;
      end
   end

endmodule

// File: tb/tb_alu_regfile.sv
// Self-checking bench for alu_regfile: directed steps followed by random
// traffic compared against an arithmetic reference model.
module tb_alu_regfile;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] rd, rs;
   logic [7:0] imm;
   logic [3:0] alu_op;
   logic       alu_src, mem_to_reg, reg_wr;
   logic [7:0] mem_data;
   logic [7:0] alu_out;
   logic       alu_zero;
   logic [7:0] mem_wr_data;

   int checks = 0;
   int errors = 0;
   int model_rf [4];

   always #5 clk = ~clk;

   alu_regfile #(.WIDTH(8), .NREGS(4)) dut (
      .clk(clk), .rst(rst), .rd(rd), .rs(rs), .imm(imm), .alu_op(alu_op),
      .alu_src(alu_src), .mem_to_reg(mem_to_reg), .mem_data(mem_data),
      .reg_wr(reg_wr), .alu_out(alu_out), .alu_zero(alu_zero),
      .mem_wr_data(mem_wr_data)
   );

   function automatic int ref_alu(int op, int a, int b);
      int s;
      s = b % 8;
      case (op)
         0: return b;
         1: return (a + b) % 256;
         2: return (a - b + 256) % 256;
         3: return a & b;
         4: return a | b;
         5: return a ^ b;
         6: return 255 - (a & b);
         7: return 255 - a;
         8: return (a * (1 << s)) % 256;
         9: return a / (1 << s);
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [1:0] t_rd, input logic [1:0] t_rs, input logic [7:0] t_imm,
                        input logic [3:0] t_op, input logic t_src, input logic t_m2r,
                        input logic [7:0] t_md, input logic t_wr);
      rd = t_rd; rs = t_rs; imm = t_imm; alu_op = t_op;
      alu_src = t_src; mem_to_reg = t_m2r; mem_data = t_md; reg_wr = t_wr;
      #1;
   endtask

   // Compare all combinational outputs against the model for the current inputs.
   task automatic check_model(input string tag);
      int a, b, r;
      a = model_rf[rd];
      b = alu_src ? int'(imm) : model_rf[rs];
      r = ref_alu(int'(alu_op), a, b);
      chk({tag, "_alu"}, alu_out, 8'(r));
      chk({tag, "_zero"}, {7'd0, alu_zero}, {7'd0, r == 0});
      chk({tag, "_st"}, mem_wr_data, 8'(a));
   endtask

   // Advance one edge, committing the model exactly as the edge should.
   task automatic clock();
      int nxt [4];
      int a, b, r;
      nxt = model_rf;
      if (rst === 1'b1) begin
         foreach (nxt[i]) nxt[i] = 0;
      end else if (reg_wr === 1'b1) begin
         a = model_rf[rd];
         b = alu_src ? int'(imm) : model_rf[rs];
         r = ref_alu(int'(alu_op), a, b);
         nxt[rd] = mem_to_reg ? int'(mem_data) : r;
      end
      @(posedge clk);
      model_rf = nxt;
      #1;
   endtask

   task automatic read_all(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
      logic [7:0] exp_v [4];
      exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
      for (int r = 0; r < 4; r++) begin
         drive(2'(r), 2'(r), 8'h00, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
         chk({tag, "_rd"}, mem_wr_data, exp_v[r]);
         chk({tag, "_rs"}, alu_out, exp_v[r]);
      end
   endtask

   initial begin
      logic [7:0] load_v [4];
      load_v[0] = 8'h7A; load_v[1] = 8'h8A; load_v[2] = 8'h9A; load_v[3] = 8'hFD;
      foreach (model_rf[i]) model_rf[i] = 0;

      // Reset
      rst = 1'b1;
      drive(2'd0, 2'd0, 8'h00, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      read_all("reset", 8'h00, 8'h00, 8'h00, 8'h00);
      drive(2'd0, 2'd0, 8'h00, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("reset_zero", {7'd0, alu_zero}, 8'h01);

      // Load path, including same-cycle old-value read
      for (int r = 0; r < 4; r++) begin
         drive(2'(r), 2'(r), 8'h00, 4'd0, 1'b0, 1'b1, load_v[r], 1'b1);
         chk("load_old", mem_wr_data, 8'h00);
         clock();
         drive(2'(r), 2'(r), 8'h00, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
         chk("load_new", mem_wr_data, load_v[r]);
      end

      // ALU via immediate on ra
      drive(2'd0, 2'd0, 8'h86, 4'd1, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("add_wrap", alu_out, 8'h00);
      chk("add_wrap_zero", {7'd0, alu_zero}, 8'h01);
      drive(2'd0, 2'd0, 8'h0F, 4'd3, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("and_imm", alu_out, 8'h0A);
      chk("and_imm_zero", {7'd0, alu_zero}, 8'h00);
      drive(2'd0, 2'd0, 8'h01, 4'd8, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("shl_imm", alu_out, 8'hF4);

      // Register-register ops: rd=rb, rs=rc
      drive(2'd1, 2'd2, 8'h00, 4'd2, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("sub_rr", alu_out, 8'hF0);
      drive(2'd1, 2'd2, 8'h00, 4'd7, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("not_rr", alu_out, 8'h75);
      drive(2'd1, 2'd2, 8'h00, 4'd5, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("xor_rr", alu_out, 8'h10);
      clock();
      read_all("after_xor", 8'h7A, 8'h10, 8'h9A, 8'hFD);

      // Write gating
      drive(2'd2, 2'd0, 8'h00, 4'd0, 1'b0, 1'b1, 8'h55, 1'b0);
      clock();
      read_all("no_wr", 8'h7A, 8'h10, 8'h9A, 8'hFD);

      // Reserved opcode
      drive(2'd3, 2'd0, 8'hFF, 4'd12, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("rsvd12", alu_out, 8'h00);
      chk("rsvd12_zero", {7'd0, alu_zero}, 8'h01);

      // Reset beats a pending write
      rst = 1'b1;
      drive(2'd3, 2'd0, 8'h00, 4'd0, 1'b0, 1'b1, 8'hAA, 1'b1);
      clock();
      rst = 1'b0;
      read_all("rst_wr", 8'h00, 8'h00, 8'h00, 8'h00);

      // Random traffic against the model, occasional mid-sequence reset
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 24) == 0);
         drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom),
               4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 8'($urandom),
               1'($urandom_range(0, 3) != 0));
         check_model("rand");
         clock();
      end
      rst = 1'b0;
      for (int r = 0; r < 4; r++) begin
         drive(2'(r), 2'(r), 8'h00, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
         check_model("final");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
